// File: rtl/systolic_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : systolic_tile_sequencer
// Purpose  : Sequences one systolic-array tile. A tile clears the array,
//            loads N_COLS weight vectors, streams k_len activation beats,
//            drains the pipeline with zero activations and then reports
//            completion. The tile can be cancelled at any point with abort.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_tile_sequencer #(
    parameter int N_ROWS = 14,
    parameter int N_COLS = 14,
    parameter int PIPE   = 1,
    parameter int K_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [K_W-1:0]    cfg_k_len,
    input  logic [N_ROWS-1:0] cfg_row_mask,
    input  logic              abort,
    input  logic              act_valid,
    output logic              act_ready,
    output logic              act_zero,
    output logic              wgt_rd_req,
    output logic              sa_en,
    output logic              sa_clr,
    output logic              sa_load_weight,
    output logic [N_ROWS-1:0] sa_row_en,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [31:0]       stall_cnt
);

    // Drain time: the last activation must travel through every row and
    // column of the array plus the PE pipeline before results are final.
    localparam int c_DRAIN_LEN = N_ROWS + N_COLS - 2 + PIPE;
    localparam int c_CNT_MAX   = (c_DRAIN_LEN > N_COLS) ? c_DRAIN_LEN : N_COLS;
    localparam int c_CNT_W     = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_LOAD_LAST  = c_CNT_W'(N_COLS - 1);
    localparam logic [c_CNT_W-1:0] c_DRAIN_LAST = c_CNT_W'(c_DRAIN_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [K_W-1:0]     c_K_ONE      = K_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_LOAD_W = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_nxt;

    logic [c_CNT_W-1:0]  r_cnt;
    logic [K_W-1:0]      r_k_len;
    logic [K_W-1:0]      r_beat;
    logic [N_ROWS-1:0]   r_mask;
    logic [31:0]         r_stall;

    logic                r_cfg_ready;
    logic                r_busy;
    logic                r_sa_clr;
    logic                r_load_w;
    logic                r_act_ready;
    logic                r_act_zero;
    logic                r_done;
    logic                r_aborted;
    logic [N_ROWS-1:0]   r_row_en;

    logic                w_accept;
    logic                w_abort;
    logic                w_last_beat;
    logic [N_ROWS-1:0]   w_mask_in;

    // An empty row mask means "use the whole array".
    assign w_mask_in   = (cfg_row_mask == '0) ? '1 : cfg_row_mask;
    assign w_accept    = cfg_valid && (r_state == S_IDLE);
    assign w_abort     = abort && (r_state != S_IDLE);
    assign w_last_beat = act_valid && (r_beat == (r_k_len - c_K_ONE));

    // Next-state selection; abort overrides every other transition.
    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (cfg_valid) w_nxt = S_CLEAR;
            S_CLEAR:  w_nxt = (r_k_len == '0) ? S_DONE : S_LOAD_W;
            S_LOAD_W: if (r_cnt == c_LOAD_LAST) w_nxt = S_STREAM;
            S_STREAM: if (w_last_beat) w_nxt = S_DRAIN;
            S_DRAIN:  if (r_cnt == c_DRAIN_LAST) w_nxt = S_DONE;
            S_DONE:   w_nxt = S_IDLE;
            default:  w_nxt = S_IDLE;
        endcase
        if (w_abort) begin
            w_nxt = S_IDLE;
        end
    end

    // State register with outputs registered from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_sa_clr    <= 1'b0;
            r_load_w    <= 1'b0;
            r_act_ready <= 1'b0;
            r_act_zero  <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_row_en    <= '0;
        end else begin
            r_state     <= w_nxt;
            r_cfg_ready <= (w_nxt == S_IDLE);
            r_busy      <= (w_nxt != S_IDLE);
            r_sa_clr    <= (w_nxt == S_CLEAR);
            r_load_w    <= (w_nxt == S_LOAD_W);
            r_act_ready <= (w_nxt == S_STREAM);
            r_act_zero  <= (w_nxt == S_DRAIN);
            r_done      <= (w_nxt == S_DONE);
            r_aborted   <= w_abort;
            if (w_nxt == S_IDLE) begin
                r_row_en <= '0;
            end else if (w_accept) begin
                r_row_en <= w_mask_in;
            end else begin
                r_row_en <= r_mask;
            end
        end
    end

    // Phase counter shared by LOAD_W and DRAIN; restarts on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_nxt != r_state) begin
            r_cnt <= '0;
        end else if ((r_state == S_LOAD_W) || (r_state == S_DRAIN)) begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    // Command capture and activation beat counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k_len <= '0;
            r_mask  <= '0;
            r_beat  <= '0;
        end else if (w_accept) begin
            r_k_len <= cfg_k_len;
            r_mask  <= w_mask_in;
            r_beat  <= '0;
        end else if ((r_state == S_STREAM) && act_valid) begin
            r_beat  <= r_beat + c_K_ONE;
        end
    end

    // Saturating count of STREAM cycles starved of activations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= '0;
        end else if (w_accept) begin
            r_stall <= '0;
        end else if ((r_state == S_STREAM) && !act_valid && (r_stall != '1)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign cfg_ready      = r_cfg_ready;
    assign busy           = r_busy;
    assign sa_clr         = r_sa_clr;
    assign sa_load_weight = r_load_w;
    assign wgt_rd_req     = r_load_w;
    assign act_ready      = r_act_ready;
    assign act_zero       = r_act_zero;
    // The array only advances on real activations while streaming, and
    // free-runs during drain to flush partial sums out.
    assign sa_en          = (r_act_ready && act_valid) || r_act_zero;
    assign done           = r_done;
    assign aborted        = r_aborted;
    assign sa_row_en      = r_row_en;
    assign stall_cnt      = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_systolic_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_tile_sequencer
// Purpose  : Self-checking bench for systolic_tile_sequencer. A timeline
//            model predicts every output each cycle; directed tiles pin the
//            model to hand-computed latencies and counts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_tile_sequencer;

    localparam int NR = 14;
    localparam int NC = 14;
    localparam int PP = 1;
    localparam int KW = 16;
    localparam int DR = NR + NC - 2 + PP;

    localparam int P_IDLE = 0, P_CLEAR = 1, P_LOAD = 2, P_STREAM = 3, P_DRAIN = 4, P_DONE = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [KW-1:0] cfg_k_len;
    logic [NR-1:0] cfg_row_mask;
    logic          abort;
    logic          act_valid;
    logic          act_ready;
    logic          act_zero;
    logic          wgt_rd_req;
    logic          sa_en;
    logic          sa_clr;
    logic          sa_load_weight;
    logic [NR-1:0] sa_row_en;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [31:0]   stall_cnt;

    systolic_tile_sequencer #(.N_ROWS(NR), .N_COLS(NC), .PIPE(PP), .K_W(KW)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_k_len(cfg_k_len), .cfg_row_mask(cfg_row_mask), .abort(abort),
        .act_valid(act_valid), .act_ready(act_ready), .act_zero(act_zero),
        .wgt_rd_req(wgt_rd_req), .sa_en(sa_en), .sa_clr(sa_clr),
        .sa_load_weight(sa_load_weight), .sa_row_en(sa_row_en), .busy(busy),
        .done(done), .aborted(aborted), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    endtask

    // ---------------- timeline model ----------------
    bit            m_active;
    int            m_n;           // cycles since accept (1 = first cycle after accept)
    int            m_k;
    logic [NR-1:0] m_mask;
    int            m_beats;
    int            m_drain_start; // cycle index of first drain cycle, 0 = not known yet
    longint        m_stalls;
    bit            m_abort_pulse;

    function automatic int phase_of();
        if (!m_active) return P_IDLE;
        if (m_n == 1) return P_CLEAR;
        if (m_k == 0) return P_DONE;
        if (m_n <= NC + 1) return P_LOAD;
        if (m_drain_start == 0 || m_n < m_drain_start) return P_STREAM;
        if (m_n < m_drain_start + DR) return P_DRAIN;
        return P_DONE;
    endfunction

    // ---------------- observation counters ----------------
    int            since;
    int            obs_clr, obs_load, obs_ready, obs_zero, obs_sa_en, obs_sa_en_low;
    int            obs_done_at;
    bit            obs_done_seen;
    int            obs_aborted;
    logic          obs_ab_ready;
    logic [NR-1:0] obs_ab_rowen;
    logic [NR-1:0] obs_rowen_busy;

    // One clock cycle: drive inputs after the falling edge, compare, advance model.
    task automatic step(input bit v_rst, input bit v_cfg, input logic [KW-1:0] v_k,
                        input logic [NR-1:0] v_mask, input bit v_abort, input bit v_act);
        int ph;
        logic [9:0] exp_bits, got_bits;
        @(negedge clk);
        rst          = v_rst;
        cfg_valid    = v_cfg;
        cfg_k_len    = v_k;
        cfg_row_mask = v_mask;
        abort        = v_abort;
        act_valid    = v_act;
        if (v_rst) begin
            m_active = 0; m_stalls = 0; m_abort_pulse = 0;
        end
        #1;
        ph = phase_of();
        exp_bits = {!m_active, m_active, ph == P_CLEAR, ph == P_LOAD, ph == P_LOAD,
                    ph == P_STREAM, (ph == P_STREAM && v_act) || ph == P_DRAIN,
                    ph == P_DRAIN, ph == P_DONE, m_abort_pulse};
        got_bits = {cfg_ready, busy, sa_clr, sa_load_weight, wgt_rd_req,
                    act_ready, sa_en, act_zero, done, aborted};
        chk("ctrl{rdy,busy,clr,ldw,wrq,ardy,en,zero,done,abrt}", 64'(got_bits), 64'(exp_bits));
        chk("sa_row_en", 64'(sa_row_en), m_active ? 64'(m_mask) : 64'd0);
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stalls));

        since++;
        if (sa_clr) obs_clr++;
        if (sa_load_weight) obs_load++;
        if (act_ready) obs_ready++;
        if (act_zero) obs_zero++;
        if (sa_en) obs_sa_en++;
        if (act_ready && !sa_en) obs_sa_en_low++;
        if (busy) obs_rowen_busy = sa_row_en;
        if (done) begin obs_done_at = since; obs_done_seen = 1; end
        if (aborted) begin obs_aborted++; obs_ab_ready = cfg_ready; obs_ab_rowen = sa_row_en; end
        if (!v_rst && cfg_valid && cfg_ready) begin
            since = 0; obs_clr = 0; obs_load = 0; obs_ready = 0; obs_zero = 0;
            obs_sa_en = 0; obs_sa_en_low = 0; obs_done_at = -1; obs_done_seen = 0;
        end

        if (!v_rst) begin
            m_abort_pulse = 0;
            if (m_active) begin
                if (ph == P_STREAM && !v_act && m_stalls < 64'hFFFF_FFFF) m_stalls++;
                if (ph == P_STREAM && v_act) begin
                    m_beats++;
                    if (m_beats == m_k) m_drain_start = m_n + 1;
                end
                if (v_abort) begin m_active = 0; m_abort_pulse = 1; end
                else if (ph == P_DONE) m_active = 0;
                else m_n++;
            end else if (v_cfg) begin
                m_active = 1; m_n = 1; m_k = int'(v_k);
                m_mask = (v_mask == '0) ? '1 : v_mask;
                m_beats = 0; m_drain_start = 0; m_stalls = 0;
            end
        end
    endtask

    // Issue one tile; optional stall window, abort cycle or reset cycle (0 = none).
    task automatic run_cmd(input int k, input logic [NR-1:0] mask, input int s_from,
                           input int s_len, input int abort_at, input int rst_at);
        bit ended;
        ended = 0;
        step(0, 1, KW'(k), mask, 0, 1);
        for (int i = 0; i < 300; i++) begin
            int  nxt;
            bit  v_act, v_ab, v_r;
            nxt   = since + 1;
            v_act = !(nxt >= s_from && nxt < s_from + s_len);
            v_ab  = (nxt == abort_at);
            v_r   = (nxt == rst_at);
            step(v_r, 0, '0, '0, v_ab, v_act);
            if (obs_done_seen || v_ab || v_r) begin ended = 1; break; end
        end
        chk("tile_ended_within_budget", 64'(ended), 64'd1);
    endtask

    initial begin
        rst = 1; cfg_valid = 0; cfg_k_len = '0; cfg_row_mask = '0; abort = 0; act_valid = 0;
        m_active = 0; m_stalls = 0; m_abort_pulse = 0; m_n = 0; m_k = 0; m_mask = '0;
        m_beats = 0; m_drain_start = 0;
        since = 0; obs_done_at = -1; obs_done_seen = 0; obs_aborted = 0;
        obs_clr = 0; obs_load = 0; obs_ready = 0; obs_zero = 0; obs_sa_en = 0; obs_sa_en_low = 0;
        obs_ab_ready = 0; obs_ab_rowen = '0; obs_rowen_busy = '0;

        // reset held, then an idle cycle with an ignored abort
        for (int i = 0; i < 3; i++) step(1, 0, '0, '0, 0, 0);
        step(0, 0, '0, '0, 1, 0);

        // defaults, k=4, act_valid always high
        run_cmd(4, 14'h3FFF, 0, 0, 0, 0);
        chk("k4_done_latency", 64'(obs_done_at), 64'd47);
        chk("k4_clr_cycles", 64'(obs_clr), 64'd1);
        chk("k4_load_cycles", 64'(obs_load), 64'd14);
        chk("k4_act_ready_beats", 64'(obs_ready), 64'd4);
        chk("k4_act_zero_cycles", 64'(obs_zero), 64'd27);
        chk("k4_stall_cnt", 64'(stall_cnt), 64'd0);

        // k=3 with two starved cycles right after the first beat
        run_cmd(3, 14'h3FFF, 17, 2, 0, 0);
        chk("k3_stall_done_latency", 64'(obs_done_at), 64'd48);
        chk("k3_stall_cnt", 64'(stall_cnt), 64'd2);
        chk("k3_sa_en_low_cycles", 64'(obs_sa_en_low), 64'd2);

        // k=0: clear then done
        run_cmd(0, 14'h0005, 0, 0, 0, 0);
        chk("k0_done_latency", 64'(obs_done_at), 64'd2);
        chk("k0_load_cycles", 64'(obs_load), 64'd0);
        chk("k0_sa_en_cycles", 64'(obs_sa_en), 64'd0);

        // row masks
        run_cmd(2, 14'h0000, 0, 0, 0, 0);
        chk("mask0_row_en", 64'(obs_rowen_busy), 64'h3FFF);
        run_cmd(2, 14'h0005, 0, 0, 0, 0);
        chk("mask5_row_en", 64'(obs_rowen_busy), 64'h0005);
        step(0, 0, '0, '0, 0, 0);
        chk("mask5_row_en_after_done", 64'(sa_row_en), 64'd0);

        // abort in DRAIN (drain spans cycles 18..44 for k=2), immediate re-issue
        obs_aborted = 0;
        run_cmd(2, 14'h3FFF, 0, 0, 22, 0);
        chk("abort_no_done", 64'(obs_done_seen), 64'd0);
        run_cmd(1, 14'h00F0, 0, 0, 0, 0);
        chk("abort_pulse_count", 64'(obs_aborted), 64'd1);
        chk("abort_idle_cfg_ready", 64'(obs_ab_ready), 64'd1);
        chk("abort_idle_row_en", 64'(obs_ab_rowen), 64'd0);
        chk("after_abort_done_latency", 64'(obs_done_at), 64'd44);

        // reset in STREAM, then a normal tile
        run_cmd(4, 14'h3FFF, 0, 0, 0, 17);
        chk("rst_midtile_busy", 64'(busy), 64'd0);
        run_cmd(4, 14'h3FFF, 0, 0, 0, 0);
        chk("after_rst_done_latency", 64'(obs_done_at), 64'd47);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            bit v_rst, v_cfg, v_ab, v_act;
            v_rst = ($urandom_range(0, 499) == 0);
            v_cfg = ($urandom_range(0, 9) < 3);
            v_ab  = ($urandom_range(0, 79) == 0);
            v_act = ($urandom_range(0, 3) != 0);
            step(v_rst, v_cfg, KW'($urandom_range(0, 10)), NR'($urandom), v_ab, v_act);
        end
        for (int i = 0; i < 3; i++) step(0, 0, '0, '0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/systolic_tile_sequencer.md
SYSTOLIC_TILE_SEQUENCER -- requirements
Module: systolic_tile_sequencer

Interface
REQ-001 SHALL have parameter N_ROWS, default 14, meaning array row count.
REQ-002 SHALL have parameter N_COLS, default 14, meaning array column count.
REQ-003 SHALL have parameter PIPE, default 1, meaning PE pipeline depth.
REQ-004 SHALL have parameter K_W, default 16, meaning width of reduction-length field.
REQ-005 SHALL have ports:
  - clk  in  1  sole clock.
  - rst  in  1  reset; asynchronous, active-high.
  - cfg_valid  in  1  tile command valid.
  - cfg_ready  out  1  sequencer can accept a command.
  - cfg_k_len  in  K_W  activation beats to stream.
  - cfg_row_mask  in  N_ROWS  rows enabled for the tile.
  - abort  in  1  synchronous cancel.
  - act_valid  in  1  activation vector available.
  - act_ready  out  1  activation vector consumed this cycle.
  - act_zero  out  1  datapath feeds zero activations (drain).
  - wgt_rd_req  out  1  weight vector requested this cycle.
  - sa_en  out  1  array en.
  - sa_clr  out  1  array clr.
  - sa_load_weight  out  1  array load_weight.
  - sa_row_en  out  N_ROWS  array row_en.
  - busy  out  1  tile in progress.
  - done  out  1  one-cycle completion pulse.
  - aborted  out  1  one-cycle abort pulse.
  - stall_cnt  out  32  STREAM cycles with act_valid low.

Function
REQ-006 SHALL implement states IDLE, CLEAR, LOAD_W, STREAM, DRAIN, DONE.
REQ-007 In IDLE, cfg_ready SHALL be 1; elsewhere 0.
REQ-008 On cfg_valid&cfg_ready, SHALL latch cfg_k_len and cfg_row_mask, clear stall_cnt to 0, and enter CLEAR; a row_mask of 0 SHALL be latched as all-ones.
REQ-009 CLEAR SHALL last 1 cycle with sa_clr=1, then enter LOAD_W, or DONE if latched k_len==0.
REQ-010 LOAD_W SHALL last exactly N_COLS cycles with sa_load_weight=1 and wgt_rd_req=1, then enter STREAM.
REQ-011 In STREAM, act_ready SHALL be 1, and sa_en SHALL equal act_valid.
REQ-012 In STREAM, a beat counter SHALL advance only on act_valid; after beat k_len, the FSM SHALL enter DRAIN.
REQ-013 In STREAM, each cycle with act_valid=0 SHALL increment stall_cnt, saturating at 2^32-1.
REQ-014 DRAIN SHALL last exactly N_ROWS+N_COLS-2+PIPE cycles with sa_en=1 and act_zero=1, then enter DONE.
REQ-015 DONE SHALL last 1 cycle with done=1, then enter IDLE.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 sa_row_en SHALL equal the latched mask while busy, and 0 in IDLE.
REQ-018 abort while busy SHALL:
  - force IDLE on the next edge;
  - pulse aborted for that one cycle;
  - suppress done.
REQ-019 abort in IDLE SHALL be ignored, and abort SHALL take priority over any same-cycle state transition.
REQ-020 Unless stated above, sa_en, sa_clr, sa_load_weight, wgt_rd_req, act_ready, act_zero, done and aborted SHALL be 0.
REQ-021 With no stalls and k_len>0, done SHALL be high exactly 2+N_COLS+k_len+(N_ROWS+N_COLS-2+PIPE) cycles after the accept edge (47 for defaults, k_len=4).

Reset
REQ-022 While rst=1, SHALL asynchronously force IDLE, clear all counters and latched config, and drive cfg_ready=1, stall_cnt=0, and every other output 0.
REQ-023 Reset deassertion mid-tile SHALL resume from IDLE, with no done or aborted pulse.

Verification
REQ-024 Defaults, k_len=4, mask=0x3FFF, act_valid tied 1:
  - sa_clr 1 cycle;
  - sa_load_weight 14 cycles;
  - 4 act_ready beats;
  - 27 act_zero cycles;
  - done at accept+47;
  - stall_cnt=0.
REQ-025 k_len=3 with act_valid low for 2 cycles mid-STREAM -> done at accept+48, stall_cnt=2, sa_en low exactly during those 2 cycles.
REQ-026 k_len=0 -> CLEAR then DONE, done at accept+2, no sa_load_weight or sa_en.
REQ-027 abort asserted during DRAIN:
  - aborted pulse;
  - IDLE next cycle with sa_row_en=0 and cfg_ready=1;
  - done never asserted;
  - new command accepted on the following cycle.
REQ-028 mask=0 -> sa_row_en=0x3FFF while busy; mask=0x0005 -> sa_row_en=0x0005 while busy and 0 after done.
REQ-029 rst pulsed in STREAM -> all outputs at reset values within the same cycle, and the next command completes with normal latency.
